fifo_rd_packer: RTL and testbench

- Read-side consumer of the dual-clock FIFO; runs entirely in the FIFO read clock domain.
- Pops 16-bit words using the FIFO's first-word-fall-through handshake (rd_request = not empty, rd_en = pop).
- Packs RATIO consecutive words into one wide word.
- Presents each wide word to the downstream datapath on a registered valid/ready stream.

---
 rtl/fifo_rd_pkg.sv | 10 +
 rtl/fifo_rd_out_reg.sv | 56 +++++
 rtl/fifo_rd_packer.sv | 118 +++++++++++
 tb/tb_fifo_rd_packer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-side packer.
package fifo_rd_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultRatio = 2;
  localparam int unsigned SEQ_CNT_W    = 16;

  typedef logic [DefaultDataW*DefaultRatio-1:0] pack_word_t;

endpackage

// File: rtl/fifo_rd_out_reg.sv
// Output holding register: a valid/ready stage that loads a new pack or retires on accept.
module fifo_rd_out_reg
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DataW  = DefaultDataW * DefaultRatio,
  parameter int unsigned LanesW = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DataW-1:0]  load_data_i,
  input  logic [LanesW-1:0] load_lanes_i,
  input  logic              ready_i,
  output logic [DataW-1:0]  data_o,
  output logic [LanesW-1:0] lanes_o,
  output logic              valid_o,
  output logic              slot_free_o
);

  logic [DataW-1:0]  data_q, data_d;
  logic [LanesW-1:0] lanes_q, lanes_d;
  logic              valid_q, valid_d;

  assign slot_free_o = !valid_q || ready_i;

  // A load in the accept cycle wins, so back-to-back packs never drop valid.
  always_comb begin
    data_d  = data_q;
    lanes_d = lanes_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = load_data_i;
      lanes_d = load_lanes_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign lanes_o = lanes_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FWFT FIFO words and packs RATIO of them into one wide valid/ready word.
// Optional sequence checker enabled by FIFO_RD_PACKER_SEQ_CHECK_EN.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned RATIO  = DefaultRatio,
  parameter int unsigned IDX_W  = $clog2(RATIO)
) (
  input  logic                     clk_rd,
  input  logic                     reset,
  input  logic                     rd_request,
  input  logic [DATA_W-1:0]        data_out,
  output logic                     rd_en,
  input  logic                     flush,
  output logic [DATA_W*RATIO-1:0]  out_data,
  output logic [IDX_W:0]           out_lanes,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     seq_err,
  output logic [SEQ_CNT_W-1:0]     seq_err_cnt
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [RATIO-2:0][DATA_W-1:0] acc_q, acc_d;
  logic                         flush_pend_q, flush_pend_d;
  logic [RATIO-1:0][DATA_W-1:0] lanes;
  logic [IDX_W:0]               fill;
  logic                         slot_free, pop, emit, flush_req;

  // A pending flush blocks pops so the partial pack cannot be overwritten.
  assign rd_en = reset && rd_request && !flush_pend_q && ((idx_q != LastIdx) || slot_free);
  assign pop   = rd_en;

  always_comb begin
    lanes = {{DATA_W{1'b0}}, acc_q};
    if (pop) begin
      lanes[idx_q] = data_out;
    end
    fill         = {1'b0, idx_q} + {{IDX_W{1'b0}}, pop};
    flush_req    = flush || flush_pend_q;
    emit         = (pop && (idx_q == LastIdx)) || (flush_req && (fill != '0) && slot_free);
    flush_pend_d = flush_req && (fill != '0) && !emit;
    if (emit) begin
      idx_d = '0;
      acc_d = '0;
    end else begin
      idx_d = fill[IDX_W-1:0];
      acc_d = lanes[RATIO-2:0];
    end
  end

  always_ff @(posedge clk_rd or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  fifo_rd_out_reg #(
    .DataW  (DATA_W * RATIO),
    .LanesW (IDX_W + 1)
  ) u_out_reg (
    .clk_i        (clk_rd),
    .rst_ni       (reset),
    .load_i       (emit),
    .load_data_i  (lanes),
    .load_lanes_i (fill),
    .ready_i      (out_ready),
    .data_o       (out_data),
    .lanes_o      (out_lanes),
    .valid_o      (out_valid),
    .slot_free_o  (slot_free)
  );

`ifdef FIFO_RD_PACKER_SEQ_CHECK_EN
  logic [DATA_W-1:0]    last_q;
  logic                 seeded_q;
  logic                 seq_err_q;
  logic [SEQ_CNT_W-1:0] seq_cnt_q;

  // First pop after reset only seeds the tracker.
  always_ff @(posedge clk_rd or negedge reset) begin
    if (!reset) begin
      last_q    <= '0;
      seeded_q  <= 1'b0;
      seq_err_q <= 1'b0;
      seq_cnt_q <= '0;
    end else begin
      seq_err_q <= 1'b0;
      if (pop) begin
        last_q   <= data_out;
        seeded_q <= 1'b1;
        if (seeded_q && (data_out != last_q + DATA_W'(1))) begin
          seq_err_q <= 1'b1;
          if (seq_cnt_q != '1) begin
            seq_cnt_q <= seq_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign seq_err     = seq_err_q;
  assign seq_err_cnt = seq_cnt_q;
`else
  assign seq_err     = 1'b0;
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue models the FWFT FIFO, expected packs are queued.
module tb_fifo_rd_packer;
  import fifo_rd_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned R  = 2;
  localparam int unsigned IW = 1;

  logic              clk;
  logic              reset;
  logic              rd_request;
  logic [DW-1:0]     data_out;
  logic              rd_en;
  logic              flush;
  pack_word_t        out_data;
  logic [IW:0]       out_lanes;
  logic              out_valid;
  logic              out_ready;
  logic              seq_err;
  logic [15:0]       seq_err_cnt;

  typedef struct {
    pack_word_t  data;
    logic [IW:0] lanes;
  } exp_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          expq[$];
  int            checks;
  int            errors;
  int            seq_pulses;
  bit            pop_pend;

  fifo_rd_packer #(
    .DATA_W (DW),
    .RATIO  (R),
    .IDX_W  (IW)
  ) dut (
    .clk_rd      (clk),
    .reset       (reset),
    .rd_request  (rd_request),
    .data_out    (data_out),
    .rd_en       (rd_en),
    .flush       (flush),
    .out_data    (out_data),
    .out_lanes   (out_lanes),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .seq_err     (seq_err),
    .seq_err_cnt (seq_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: pop decided from rd_en at negedge, applied after posedge, outputs driven at +2.
  always @(negedge clk) pop_pend = rd_en;

  always begin
    logic [DW-1:0] dummy;
    @(posedge clk);
    #1;
    if (pop_pend && fifo_q.size() != 0) dummy = fifo_q.pop_front();
    #1;
    rd_request = (fifo_q.size() != 0);
    data_out   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // Output monitor: a transfer completes at the posedge following a valid&&ready negedge.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pack got data=%h lanes=%0d required no output",
                 out_data, out_lanes);
      end else begin
        e = expq.pop_front();
        if (out_data !== e.data || out_lanes !== e.lanes) begin
          errors++;
          $display("FAIL pack got data=%h lanes=%0d required data=%h lanes=%0d",
                   out_data, out_lanes, e.data, e.lanes);
        end
      end
    end
  end

  always @(negedge clk) if (reset && seq_err) seq_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input pack_word_t d, input logic [IW:0] l);
    exp_t e;
    e.data  = d;
    e.lanes = l;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    fifo_q.delete();
    expq.delete();
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((expq.size() != 0 || fifo_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d packs outstanding required 0", name, expq.size());
    end
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b0;
    fifo_q.push_back(16'h1234);
    #2;
    checks += 6;
    if (rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_rd_en got %b required 0", rd_en);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b required 0", out_valid);
    end
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_out_data got %h required 0", out_data);
    end
    if (out_lanes !== '0) begin
      errors++; $display("FAIL reset_out_lanes got %0d required 0", out_lanes);
    end
    if (seq_err !== 1'b0) begin
      errors++; $display("FAIL reset_seq_err got %b required 0", seq_err);
    end
    if (seq_err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_seq_err_cnt got %h required 0", seq_err_cnt);
    end
    fifo_q.delete();
  endtask

  task automatic test_basic();
    bit exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
    exp_push(32'h0002_0001, 2'd2);
    exp_push(32'h0004_0003, 2'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== exp_v[i]) begin
        errors++;
        $display("FAIL basic_latency cycle %0d got valid=%b required %b", i, out_valid, exp_v[i]);
      end
    end
    tick();
    wait_drain("basic");
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) fifo_q.push_back(DW'(i));
    exp_push(32'h0002_0001, 2'd2);
    exp_push(32'h0004_0003, 2'd2);
    exp_push(32'h0006_0005, 2'd2);
    repeat (6) tick();
    checks += 4;
    if (out_valid !== 1'b1 || out_data !== 32'h0002_0001) begin
      errors++;
      $display("FAIL bp_hold got valid=%b data=%h required 1 00020001", out_valid, out_data);
    end
    if (rd_en !== 1'b0) begin
      errors++; $display("FAIL bp_rd_en got %b required 0", rd_en);
    end
    if (fifo_q.size() != 3) begin
      errors++; $display("FAIL bp_pops got %0d words left required 3", fifo_q.size());
    end
    if (expq.size() != 3) begin
      errors++; $display("FAIL bp_no_accept got %0d pending required 3", expq.size());
    end
    out_ready = 1'b1;
    wait_drain("backpressure");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle got valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush_partial();
    do_reset();
    fifo_q.push_back(16'h0007);
    exp_push(32'h0000_0007, 2'd1);
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_early got valid=%b required 0", out_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("flush_partial");
    // flush in the same cycle as the first pop
    fifo_q.push_back(16'h000a);
    exp_push(32'h0000_000a, 2'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("flush_same_pop");
    // flush in the same cycle as the completing pop yields a normal full pack
    fifo_q.push_back(16'h000b);
    repeat (2) tick();
    fifo_q.push_back(16'h000c);
    exp_push(32'h000c_000b, 2'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("flush_full");
  endtask

  task automatic test_flush_pending();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) fifo_q.push_back(DW'(i));
    exp_push(32'h0002_0001, 2'd2);
    exp_push(32'h0000_0003, 2'd1);
    exp_push(32'h0000_0004, 2'd1);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fifo_q.push_back(16'h0004);
    repeat (2) tick();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b0) begin
      errors++; $display("FAIL pend_rd_en got %b required 0", rd_en);
    end
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("flush_pending");
  endtask

  task automatic test_flush_empty();
    int hi = 0;
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL flush_empty got %0d valid cycles required 0", hi);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
    repeat (6) tick();
    #2;
    reset = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_valid got %b required 0", out_valid);
    end
    if (out_data !== '0) begin
      errors++; $display("FAIL rmid_data got %h required 0", out_data);
    end
    if (out_lanes !== '0) begin
      errors++; $display("FAIL rmid_lanes got %0d required 0", out_lanes);
    end
    if (rd_en !== 1'b0) begin
      errors++; $display("FAIL rmid_rd_en got %b required 0", rd_en);
    end
    fifo_q.delete();
    expq.delete();
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    fifo_q.push_back(16'h0008);
    fifo_q.push_back(16'h0009);
    exp_push(32'h0009_0008, 2'd2);
    wait_drain("reset_mid");
  endtask

  task automatic test_seq_check();
    int        exp_pulses;
    logic [15:0] exp_cnt;
`ifdef FIFO_RD_PACKER_SEQ_CHECK_EN
    exp_pulses = 1;
    exp_cnt    = 16'd1;
`else
    exp_pulses = 0;
    exp_cnt    = 16'd0;
`endif
    do_reset();
    seq_pulses = 0;
    fifo_q.push_back(16'h0001);
    fifo_q.push_back(16'h0002);
    fifo_q.push_back(16'h0004);
    fifo_q.push_back(16'h0005);
    exp_push(32'h0002_0001, 2'd2);
    exp_push(32'h0005_0004, 2'd2);
    wait_drain("seq");
    checks += 2;
    if (seq_pulses != exp_pulses) begin
      errors++; $display("FAIL seq_pulses got %0d required %0d", seq_pulses, exp_pulses);
    end
    if (seq_err_cnt !== exp_cnt) begin
      errors++; $display("FAIL seq_err_cnt got %0d required %0d", seq_err_cnt, exp_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    rd_request = 1'b0;
    data_out   = '0;
    checks     = 0;
    errors     = 0;
    seq_pulses = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_partial();
    test_flush_pending();
    test_flush_empty();
    test_reset_mid();
    test_seq_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
